// File: rtl/multimode_modulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multimode_modulator_pkg
//  Description : Shared definitions for the multimode modulator: modulation
//                mode codes, FSM state encoding and output level helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package multimode_modulator_pkg;

  // Modulation mode codes as presented on the mode input
  localparam logic [1:0] MODE_ASK  = 2'd0;
  localparam logic [1:0] MODE_FSK  = 2'd1;
  localparam logic [1:0] MODE_BPSK = 2'd2;
  localparam logic [1:0] MODE_NRZ  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    TX     = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Mid-scale (zero carrier) level for a given sample width
  function automatic int mid_level(input int sample_w);
    return 1 << (sample_w - 1);
  endfunction

  // Full-scale level for a given sample width
  function automatic int full_level(input int sample_w);
    return (1 << sample_w) - 1;
  endfunction

endpackage : multimode_modulator_pkg
`default_nettype wire

// File: rtl/multimode_modulator_sine_lut.sv
`default_nettype none
// ============================================================================
//  Module      : sine_lut
//  Description : Combinational sine table, one full period over 2^PHASE_W
//                entries, centred on mid-scale with amplitude MID-1.
//  Ports       : addr   in  PHASE_W   carrier phase index
//                sample out SAMPLE_W  MID + round((MID-1)*sin(2*pi*addr/N))
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_lut
  import multimode_modulator_pkg::*;
#(
  parameter int PHASE_W  = 5,
  parameter int SAMPLE_W = 8
) (
  input  logic [PHASE_W-1:0]  addr,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int  N   = 1 << PHASE_W;
  localparam int  MID = mid_level(SAMPLE_W);
  localparam real PI  = 3.141592653589793;

  logic [SAMPLE_W-1:0] w_table [N];

  // Table contents are elaboration-time constants; rounding is symmetric
  // about zero so the positive and negative half-waves mirror exactly.
  for (genvar i = 0; i < N; i++) begin : g_entry
    localparam real AMP = real'(MID - 1) * $sin(2.0 * PI * real'(i) / real'(N));
    localparam int  OFS = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
    assign w_table[i] = SAMPLE_W'(MID + OFS);
  end

  assign sample = w_table[addr];

endmodule : sine_lut
`default_nettype wire

// File: rtl/multimode_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : multimode_modulator
//  Description : Serial ASK/FSK/BPSK/NRZ modulator. Latches a frame and its
//                configuration on init, then on send shifts the frame out
//                MSB-first as a sampled carrier for the PWM DAC stage.
//  Ports       : clk    in   system clock, rising edge
//                rst    in   asynchronous reset, active-high
//                init   in   load msg/cnt/mode while IDLE or LOADED
//                send   in   start / repeat transmission while LOADED
//                mode   in   0=ASK 1=FSK 2=BPSK 3=NRZ
//                cnt    in   carrier periods per bit (0 treated as 1)
//                msg    in   frame, MSB first
//                pwm_in out  registered output sample
//                busy   out  high while transmitting
//                done   out  one-cycle pulse after the last bit
//  Revision    : 1.0 - initial release
// ============================================================================
module multimode_modulator
  import multimode_modulator_pkg::*;
#(
  parameter int MSG_W    = 5,
  parameter int SAMPLE_W = 8,
  parameter int PHASE_W  = 5,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                send,
  input  logic [1:0]          mode,
  input  logic [CNT_W-1:0]    cnt,
  input  logic [MSG_W-1:0]    msg,
  output logic [SAMPLE_W-1:0] pwm_in,
  output logic                busy,
  output logic                done
);

  localparam int N     = 1 << PHASE_W;
  localparam int BIT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam int CLK_W = CNT_W + PHASE_W;

  localparam logic [SAMPLE_W-1:0] c_mid  = SAMPLE_W'(mid_level(SAMPLE_W));
  localparam logic [SAMPLE_W-1:0] c_full = SAMPLE_W'(full_level(SAMPLE_W));
  localparam logic [PHASE_W-1:0]  c_half = PHASE_W'(N / 2);

  state_t              r_state;
  logic [MSG_W-1:0]    r_msg;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_mode;
  logic [PHASE_W-1:0]  r_phase;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [CLK_W-1:0]    r_clk_cnt;

  logic [CNT_W-1:0]    w_cnt_eff;
  logic [CLK_W-1:0]    w_bit_last;
  logic                w_bit;
  logic [PHASE_W-1:0]  w_lut_addr;
  logic [SAMPLE_W-1:0] w_lut_sample;
  logic [SAMPLE_W-1:0] w_sample;
  logic [PHASE_W-1:0]  w_phase_step;

  // Bit length is cnt whole carrier periods, i.e. cnt followed by PHASE_W zeros
  assign w_cnt_eff  = (r_cnt == '0) ? CNT_W'(1) : r_cnt;
  assign w_bit_last = {w_cnt_eff, {PHASE_W{1'b0}}} - CLK_W'(1);
  assign w_bit      = r_msg[r_bit_idx];

  // A BPSK zero is the same carrier shifted by half a period
  assign w_lut_addr = (r_mode == MODE_BPSK && !w_bit) ? r_phase + c_half : r_phase;

  // FSK marks a one by doubling the carrier frequency
  assign w_phase_step = (r_mode == MODE_FSK && w_bit) ? PHASE_W'(2) : PHASE_W'(1);

  sine_lut #(
    .PHASE_W (PHASE_W),
    .SAMPLE_W(SAMPLE_W)
  ) u_sine_lut (
    .addr  (w_lut_addr),
    .sample(w_lut_sample)
  );

  always_comb begin
    w_sample = c_mid;
    case (r_mode)
      MODE_ASK:  w_sample = w_bit ? w_lut_sample : c_mid;
      MODE_FSK:  w_sample = w_lut_sample;
      MODE_BPSK: w_sample = w_lut_sample;
      MODE_NRZ:  w_sample = w_bit ? c_full : '0;
      default:   w_sample = c_mid;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_msg     <= '0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
      pwm_in    <= c_mid;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pwm_in <= c_mid;
      done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init) begin
            r_msg   <= msg;
            r_cnt   <= cnt;
            r_mode  <= mode;
            r_state <= LOADED;
          end
        end
        LOADED: begin
          // send has priority so a held send repeats the latched frame
          if (send) begin
            r_state   <= TX;
            busy      <= 1'b1;
            r_phase   <= '0;
            r_bit_idx <= BIT_W'(MSG_W - 1);
            r_clk_cnt <= '0;
          end else if (init) begin
            r_msg  <= msg;
            r_cnt  <= cnt;
            r_mode <= mode;
          end
        end
        TX: begin
          pwm_in  <= w_sample;
          r_phase <= r_phase + w_phase_step;
          if (r_clk_cnt == w_bit_last) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == '0) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx - BIT_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CLK_W'(1);
          end
        end
        DONE: begin
          r_state <= LOADED;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : multimode_modulator
`default_nettype wire

// File: tb/tb_multimode_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multimode_modulator
//  Description : Self-checking bench for multimode_modulator. Stimulus pushes
//                expected samples and frame lengths into queues; a monitor
//                pops and compares them as the modulator produces output.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multimode_modulator;

  localparam int MSG_W    = 5;
  localparam int SAMPLE_W = 8;
  localparam int PHASE_W  = 5;
  localparam int CNT_W    = 3;
  localparam int N        = 32;
  localparam int MID      = 128;
  localparam int FULL     = 255;

  logic                clk  = 1'b0;
  logic                rst  = 1'b1;
  logic                init = 1'b0;
  logic                send = 1'b0;
  logic [1:0]          mode = 2'd0;
  logic [CNT_W-1:0]    cnt  = '0;
  logic [MSG_W-1:0]    msg  = '0;
  logic [SAMPLE_W-1:0] pwm_in;
  logic                busy;
  logic                done;

  always #2 clk = ~clk;

  multimode_modulator #(
    .MSG_W(MSG_W), .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .send(send), .mode(mode),
    .cnt(cnt), .msg(msg), .pwm_in(pwm_in), .busy(busy), .done(done)
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int len_q[$];

  bit mon_prev_busy = 1'b0;
  int mon_run       = 0;

  function automatic void check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endfunction

  // Ideal carrier sample: mid-scale plus rounded sine of amplitude MID-1
  function automatic int sine_ref(input int i);
    real a;
    a = 127.0 * $sin(2.0 * 3.141592653589793 * real'(i) / real'(N));
    return MID + $rtoi($floor(a + 0.5));
  endfunction

  // Expected sample stream of one whole frame
  function automatic void push_frame(input int m, input int c, input int md);
    int per, ph, bitv, s;
    per = ((c == 0) ? 1 : c) * N;
    ph  = 0;
    for (int b = MSG_W - 1; b >= 0; b--) begin
      bitv = (m >> b) & 1;
      for (int k = 0; k < per; k++) begin
        case (md)
          0:       begin s = bitv ? sine_ref(ph) : MID;                       ph = (ph + 1) % N; end
          1:       begin s = sine_ref(ph);                                    ph = (ph + (bitv ? 2 : 1)) % N; end
          2:       begin s = bitv ? sine_ref(ph) : sine_ref((ph + N/2) % N);  ph = (ph + 1) % N; end
          default: begin s = bitv ? FULL : 0;                                 ph = (ph + 1) % N; end
        endcase
        exp_q.push_back(s);
      end
    end
    len_q.push_back(MSG_W * per);
  endfunction

  // Monitor: a sample is valid on the cycle after busy was seen high
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_busy = 1'b0;
        mon_run       = 0;
      end else begin
        if (mon_prev_busy) begin
          if (exp_q.size() == 0) check("sample_underflow", 1, 0);
          else check("sample", int'(pwm_in), exp_q.pop_front());
        end else begin
          check("idle_pwm", int'(pwm_in), MID);
        end
        check("done_pulse", int'(done), int'(mon_prev_busy && !busy));
        if (busy) mon_run++;
        else if (mon_prev_busy) begin
          if (len_q.size() == 0) check("busy_len_underflow", 1, 0);
          else check("busy_len", mon_run, len_q.pop_front());
          mon_run = 0;
        end
        mon_prev_busy = busy;
      end
    end
  end

  // Load a configuration, hold send for nf frames; optionally scramble the
  // control inputs during transmission, which must have no effect.
  task automatic run_frames(input int m, input int c, input int md, input int nf,
                            input bit scramble);
    int got, cyc, budget;
    @(negedge clk);
    msg = MSG_W'(m); cnt = CNT_W'(c); mode = 2'(md); init = 1'b1; send = 1'b0;
    @(negedge clk);
    init = 1'b0; send = 1'b1;
    for (int f = 0; f < nf; f++) push_frame(m, c, md);
    got    = 0;
    cyc    = 0;
    budget = nf * (MSG_W * 8 * N + 8) + 16;
    while (got < nf && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) got++;
      if (scramble && busy) begin
        init = 1'($urandom);
        msg  = MSG_W'($urandom);
        cnt  = CNT_W'($urandom);
        mode = 2'($urandom);
      end else begin
        init = 1'b0;
      end
      if (got == nf) send = 1'b0;
    end
    send = 1'b0;
    init = 1'b0;
    check("frames_done", got, nf);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst  = 1'b1;
    send = 1'b0;
    init = 1'b0;
    exp_q.delete();
    len_q.delete();
    #1;
    check("async_rst_pwm", int'(pwm_in), MID);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    #21 rst = 1'b0;
    @(negedge clk);
    check("reset_pwm", int'(pwm_in), MID);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    // send without a prior init must not start anything
    send = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_send_busy", int'(busy), 0);
    end
    send = 1'b0;

    run_frames(5'b11011, 5, 0, 2, 1'b0);   // ASK, repeated frame
    run_frames(5'b10000, 1, 1, 1, 1'b0);   // FSK
    run_frames(5'b01000, 1, 2, 1, 1'b0);   // BPSK
    run_frames(5'b10101, 0, 3, 1, 1'b0);   // NRZ, cnt 0 acts as 1

    // Reset in the middle of a frame, then send alone must be ignored
    @(negedge clk);
    msg = 5'b10110; cnt = 3'd2; mode = 2'd0; init = 1'b1;
    @(negedge clk);
    init = 1'b0; send = 1'b1;
    push_frame(5'b10110, 2, 0);
    repeat (100) @(negedge clk);
    pulse_reset();
    send = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("post_rst_send_busy", int'(busy), 0);
    end
    send = 1'b0;

    // Randomized frames, some with inputs disturbed during transmission
    for (int r = 0; r < 10; r++) begin
      run_frames(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 2)),
                 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("len_q_drained", len_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_multimode_modulator
`default_nettype wire
